// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - convolution window pixel address generator
//
// Accepts a window anchor (top row, left column) and emits the K*K pixel
// read addresses of the KERNEL_SIZE x KERNEL_SIZE window in raster order
// (column fastest), one per accepted beat, with valid/ready flow control.
//
// Optional feature macro: CONV_ADDR_PAD_EN
//   defined   - positions outside the IMG_HEIGHT x IMG_WIDTH image emit a
//               beat with addr_pad=1 and addr=0
//   undefined - addr_pad is always 0 and addr wraps modulo 2^ADDR_WIDTH
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   enable         in   work enable; low returns the block to idle
//   anchor_valid   in   anchor_height/anchor_width valid
//   anchor_height  in   window top row (32 bit)
//   anchor_width   in   window left column (32 bit)
//   pause          out  upstream hold; low means an anchor is taken this cycle
//   addr           out  pixel read address (ADDR_WIDTH bits)
//   addr_valid     out  addr valid
//   addr_ready     in   consumer accepts addr
//   addr_pad       out  current position lies outside the image
//   window_last    out  addr is the final position of the window
module conv_addr_gen #(
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  anchor_valid,
  input  logic [31:0]           anchor_height,
  input  logic [31:0]           anchor_width,
  output logic                  pause,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  addr_pad,
  output logic                  window_last
);

  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);

  // Reject nonsensical geometry at elaboration time.
  if (KERNEL_SIZE < 1 || IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : g_bad_cfg
    $error("conv_addr_gen: KERNEL_SIZE, IMG_WIDTH and IMG_HEIGHT must be >= 1");
  end

  typedef enum logic {IDLE, GEN} state_t;

  state_t        state;
  logic [31:0]   anch_h;
  logic [31:0]   anch_w;
  logic [KW-1:0] kh;
  logic [KW-1:0] kw;
  logic [KW-1:0] next_kh;
  logic [KW-1:0] next_kw;

  // Returns {pad, addr} for one window position.
  function automatic logic [ADDR_WIDTH:0] pos_out(input logic [31:0] ah,
                                                  input logic [31:0] aw,
                                                  input logic [KW-1:0] ph,
                                                  input logic [KW-1:0] pw);
    logic [31:0] row;
    logic [31:0] col;
    row = ah + 32'(ph);
    col = aw + 32'(pw);
`ifdef CONV_ADDR_PAD_EN
    if (row >= 32'(IMG_HEIGHT) || col >= 32'(IMG_WIDTH)) begin
      return {1'b1, {ADDR_WIDTH{1'b0}}};
    end
`endif
    return {1'b0, ADDR_WIDTH'(32'(BASE_ADDR) + row * 32'(IMG_WIDTH) + col)};
  endfunction

  // Raster step: column fastest, row wraps when the column reaches K-1.
  always_comb begin
    next_kh = kh;
    next_kw = kw + KW'(1);
    if (kw == K_LAST) begin
      next_kw = '0;
      next_kh = kh + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state       <= IDLE;
      anch_h      <= '0;
      anch_w      <= '0;
      kh          <= '0;
      kw          <= '0;
      pause       <= 1'b0;
      addr        <= '0;
      addr_valid  <= 1'b0;
      addr_pad    <= 1'b0;
      window_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anchor_valid) begin
            anch_h                <= anchor_height;
            anch_w                <= anchor_width;
            kh                    <= '0;
            kw                    <= '0;
            state                 <= GEN;
            pause                 <= 1'b1;
            addr_valid            <= 1'b1;
            {addr_pad, addr}      <= pos_out(anchor_height, anchor_width, '0, '0);
            window_last           <= (KERNEL_SIZE == 1);
          end
        end
        GEN: begin
          // addr_valid is always high in GEN, so ready alone means a handshake.
          if (addr_ready) begin
            if (window_last) begin
              state       <= IDLE;
              kh          <= '0;
              kw          <= '0;
              pause       <= 1'b0;
              addr        <= '0;
              addr_valid  <= 1'b0;
              addr_pad    <= 1'b0;
              window_last <= 1'b0;
            end else begin
              kh               <= next_kh;
              kw               <= next_kw;
              {addr_pad, addr} <= pos_out(anch_h, anch_w, next_kh, next_kw);
              window_last      <= (next_kh == K_LAST) && (next_kw == K_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_addr_gen.md
CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

Interface
REQ-001 SHALL provide parameter IMG_WIDTH, default 32, the image row length in pixels.
REQ-002 SHALL provide parameter IMG_HEIGHT, default 32, the image row count.
REQ-003 SHALL provide parameter KERNEL_SIZE, default 3, the square window edge K, with K >= 1.
REQ-004 SHALL provide parameter ADDR_WIDTH, default 16, the output address width.
REQ-005 SHALL provide parameter BASE_ADDR, default 0, the feature-map base address.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 enable  in  1  work enable; low clears internal state.
REQ-009 anchor_valid  in  1  anchor_height/anchor_width are valid.
REQ-010 anchor_height  in  32  window top row.
REQ-011 anchor_width  in  32  window left column.
REQ-012 pause  out  1  upstream hold; low means the anchor is accepted this cycle.
REQ-013 addr  out  ADDR_WIDTH  pixel read address.
REQ-014 addr_valid  out  1  addr is valid.
REQ-015 addr_ready  in  1  consumer accepts addr.
REQ-016 addr_pad  out  1  current window position lies outside the image.
REQ-017 window_last  out  1  addr is the final position of the window.

Function
REQ-018 SHALL implement FSM states IDLE and GEN.
REQ-019 In IDLE: pause=0 and addr_valid=0; when enable & anchor_valid, SHALL capture both anchors, set kh=kw=0, and enter GEN on the next edge.
REQ-020 In GEN: pause=1; addr_valid=1 with registered outputs.
- First addr_valid SHALL appear 1 cycle after capture.
REQ-021 addr SHALL equal BASE_ADDR + (anchor_height+kh)*IMG_WIDTH + (anchor_width+kw), computed at 32 bits and truncated to ADDR_WIDTH.
REQ-022 Window positions SHALL advance in raster order: kw fastest, then kh, each in 0..K-1; a position advances only on addr_valid & addr_ready.
REQ-023 While addr_valid & !addr_ready, addr, addr_pad and window_last SHALL hold stable.
REQ-024 window_last SHALL be 1 only at kh=kw=K-1.
- Acceptance of that position SHALL return the FSM to IDLE.
- Per-anchor cost is K*K accepted beats + 1 IDLE cycle.
REQ-025 enable low in any state SHALL, on the next edge, force IDLE and clear kh, kw, captured anchors and all outputs to 0 (pause=0).
REQ-026 anchor_valid while in GEN SHALL be ignored; pause=1 protects it.

Reset
REQ-027 When rst=1 at an edge, the block SHALL force IDLE, kh=kw=0, captured anchors=0, addr=0, addr_valid=0, addr_pad=0, window_last=0, pause=0.
REQ-028 Reset SHALL take priority over enable, and a window in progress SHALL be discarded without further beats.

Configuration
REQ-029 Macro CONV_ADDR_PAD_EN defined: a position with row >= IMG_HEIGHT or col >= IMG_WIDTH SHALL emit a beat with addr_pad=1 and addr=0; the beat count is unchanged.
REQ-030 Macro CONV_ADDR_PAD_EN undefined: addr_pad SHALL be tied 0 and addr SHALL follow REQ-021 unchecked, wrapping modulo 2^ADDR_WIDTH.

Verification (K=3, IMG 32x32, BASE_ADDR=0, ADDR_WIDTH=16)
REQ-031 Anchor (0,0), addr_ready=1 -> addr 0,1,2,32,33,34,64,65,66 on 9 consecutive cycles starting 1 cycle after capture; window_last only on 66; pause high exactly 9 cycles.
REQ-032 Anchor (1,2), addr_ready low on beats 3-5 -> addr 36 held 3 extra cycles; full sequence 34,35,36,66,67,68,98,99,100 with no loss or duplication.
REQ-033 Anchor (31,31), macro defined -> beat 1 addr=1023 with addr_pad=0, then 8 beats with addr_pad=1 and addr=0; window_last on beat 9.
REQ-034 Anchor (31,31), macro undefined -> addr 1023,1024,1025,1055,1056,1057,1087,1088,1089; addr_pad always 0.
REQ-035 Anchor (0,0): enable dropped after beat 4 -> next cycle addr_valid=0, pause=0; a new anchor (0,1) then yields 1,2,3,33,... .
REQ-036 rst=1 during beat 5 -> next cycle all outputs 0 and IDLE; simultaneous rst and enable both high -> reset wins.
